// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU output-port distribution path.
package mcu_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // One-hot decode of a channel select.
    function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_slot_nb.sv
// One-entry holding register for a single distributor output channel.
module demux_slot_nb #(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fill,
    input  logic [n-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [n-1:0] dout,
    output logic         slot_rdy
);

    // Slot can take a word when empty or when the sink drains it this cycle.
    assign slot_rdy = ~out_valid | out_ready;

    // Fill wins over drain; a drain alone clears the flag but keeps the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (fill) begin
            out_valid <= 1'b1;
            dout      <= din;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1t4_nb.sv
// Registered 1-to-4 distributor with a one-entry slot per output channel.
module demux_1t4_nb
    import mcu_pkg::*;
#(
    parameter int unsigned n = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [n-1:0]      in_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [n-1:0]      out_data0,
    output logic [n-1:0]      out_data1,
    output logic [n-1:0]      out_data2,
    output logic [n-1:0]      out_data3,
    output logic              busy
);

    logic [NUM_CH-1:0] slot_rdy;
    logic [NUM_CH-1:0] fill;
    logic [n-1:0]      dout [NUM_CH];
    logic              accept;

    // Readiness follows only the selected channel's slot.
    assign in_ready = slot_rdy[in_sel];
    assign accept   = in_valid & in_ready;
    assign fill     = accept ? sel_onehot(ch_sel_t'(in_sel)) : '0;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot_nb #(.n(n)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .fill      (fill[k]),
            .din       (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .dout      (dout[k]),
            .slot_rdy  (slot_rdy[k])
        );
    end

    assign out_data0 = dout[0];
    assign out_data1 = dout[1];
    assign out_data2 = dout[2];
    assign out_data3 = dout[3];

    assign busy = |out_valid;

endmodule
